// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: grants up to WB_PORTS of NUM_REQ result producers per cycle using
// round-robin order, with aged requesters (wait == MAX_WAIT) promoted ahead of the rotation.
module wb_port_arbiter #(
  parameter int unsigned NUM_REQ              = 4,
  parameter int unsigned WB_PORTS             = 2,
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned PHYS_REGS_ADDR_WIDTH = 6,
  parameter int unsigned ROB_ADDR_WIDTH       = 4,
  parameter int unsigned MAX_WAIT             = 7
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  input  logic [NUM_REQ*PHYS_REGS_ADDR_WIDTH-1:0]  req_phys_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data,
  input  logic [NUM_REQ*ROB_ADDR_WIDTH-1:0]        req_rob_addr,
  output logic [WB_PORTS-1:0]                      wb_valid,
  output logic [WB_PORTS*PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd,
  output logic [WB_PORTS*DATA_WIDTH-1:0]           wb_data,
  output logic [WB_PORTS*ROB_ADDR_WIDTH-1:0]       wb_rob_addr,
  output logic [$clog2(NUM_REQ)-1:0]               rr_ptr
);

  localparam int unsigned PtrW    = $clog2(NUM_REQ);
  localparam logic [7:0]  MaxWait = 8'(MAX_WAIT);

  logic [PtrW-1:0]           rr_q;
  logic [7:0]                wait_q [NUM_REQ];
  logic [WB_PORTS-1:0]       wb_valid_q;
  logic [WB_PORTS*PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_q;
  logic [WB_PORTS*DATA_WIDTH-1:0]           wb_data_q;
  logic [WB_PORTS*ROB_ADDR_WIDTH-1:0]       wb_rob_q;

  logic [NUM_REQ-1:0]  grant;
  logic [WB_PORTS-1:0] port_vld;
  logic [PtrW-1:0]     port_sel [WB_PORTS];
  logic [PtrW-1:0]     last_idx;
  logic [PtrW-1:0]     idx;
  int                  n_grant;

  // Pass 0 takes aged requesters, pass 1 the rest; both scan from rr_q.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    last_idx = rr_q;
    idx      = '0;
    n_grant  = 0;
    for (int p = 0; p < int'(WB_PORTS); p++) port_sel[p] = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        idx = PtrW'((int'(rr_q) + k) % int'(NUM_REQ));
        if (req_valid[idx] && !grant[idx] && ((wait_q[idx] == MaxWait) == (pass == 0)) &&
            n_grant < int'(WB_PORTS)) begin
          grant[idx] = 1'b1;
          for (int p = 0; p < int'(WB_PORTS); p++) begin
            if (n_grant == p) begin
              port_sel[p] = idx;
              port_vld[p] = 1'b1;
            end
          end
          last_idx = idx;
          n_grant  = n_grant + 1;
        end
      end
    end
  end

  assign req_ready   = grant & {NUM_REQ{rst & ~flush}};
  assign wb_valid    = wb_valid_q;
  assign wb_phys_rd  = wb_phys_q;
  assign wb_data     = wb_data_q;
  assign wb_rob_addr = wb_rob_q;
  assign rr_ptr      = rr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q       <= '0;
      wb_valid_q <= '0;
      wb_phys_q  <= '0;
      wb_data_q  <= '0;
      wb_rob_q   <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) wait_q[i] <= '0;
    end else if (flush) begin
      wb_valid_q <= '0;
      wb_phys_q  <= '0;
      wb_data_q  <= '0;
      wb_rob_q   <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) wait_q[i] <= '0;
    end else begin
      wb_valid_q <= port_vld;
      for (int p = 0; p < int'(WB_PORTS); p++) begin
        if (port_vld[p]) begin
          wb_phys_q[p*PHYS_REGS_ADDR_WIDTH +: PHYS_REGS_ADDR_WIDTH] <=
            req_phys_rd[int'(port_sel[p])*PHYS_REGS_ADDR_WIDTH +: PHYS_REGS_ADDR_WIDTH];
          wb_data_q[p*DATA_WIDTH +: DATA_WIDTH] <=
            req_data[int'(port_sel[p])*DATA_WIDTH +: DATA_WIDTH];
          wb_rob_q[p*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH] <=
            req_rob_addr[int'(port_sel[p])*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
        end else begin
          wb_phys_q[p*PHYS_REGS_ADDR_WIDTH +: PHYS_REGS_ADDR_WIDTH] <= '0;
          wb_data_q[p*DATA_WIDTH +: DATA_WIDTH]                     <= '0;
          wb_rob_q[p*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]              <= '0;
        end
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (req_valid[i] && !grant[i]) begin
          if (wait_q[i] != MaxWait) wait_q[i] <= wait_q[i] + 8'd1;
        end else begin
          wait_q[i] <= '0;
        end
      end
      if (|grant) begin
        rr_q <= (last_idx == PtrW'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
      end
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the WB_PORTS writeback ports among NUM_REQ functional-unit result producers (ALUs, multi-cycle units).
- The writeback ports drive the issue-queue wakeup bus, the physical register file write ports and ROB completion.
- Uses round-robin selection with age-based starvation override.
- Output is one registered cycle; accepted results are never dropped except on flush.

Parameters:
- NUM_REQ, 4, number of result requesters (>= WB_PORTS).
- WB_PORTS, 2, number of writeback ports (equals DISPATCH_WIDTH).
- DATA_WIDTH, 32, result data width.
- PHYS_REGS_ADDR_WIDTH, 6, physical register index width.
- ROB_ADDR_WIDTH, 4, ROB index width.
- MAX_WAIT, 7, wait count at which a requester becomes aged (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; drop all pending and registered results
- req_valid  in  NUM_REQ  requester i holds a result
- req_ready  out  NUM_REQ  requester i granted this cycle (handshake complete)
- req_phys_rd  in  NUM_REQ*PHYS_REGS_ADDR_WIDTH  destination physical reg; slice i belongs to requester i
- req_data  in  NUM_REQ*DATA_WIDTH  result value
- req_rob_addr  in  NUM_REQ*ROB_ADDR_WIDTH  ROB entry
- wb_valid  out  WB_PORTS  writeback port p valid
- wb_phys_rd  out  WB_PORTS*PHYS_REGS_ADDR_WIDTH  registered destination
- wb_data  out  WB_PORTS*DATA_WIDTH  registered result
- wb_rob_addr  out  WB_PORTS*ROB_ADDR_WIDTH  registered ROB entry
- rr_ptr  out  $clog2(NUM_REQ)  current round-robin start index (debug/verification)

Behaviour:
- Reset (rst=0, asynchronous):
  - wb_valid=0; wb_phys_rd, wb_data and wb_rob_addr = 0.
  - rr_ptr=0; all wait counters = 0.
  - req_ready forced to 0 while rst=0.
- Handshake:
  - A requester holds req_valid and its payload stable until it sees req_ready=1 in the same cycle.
  - req_ready is combinational from req_valid, the wait counters and rr_ptr; it never depends on a requester's own payload.
  - req_ready=1 only when req_valid=1.
- Selection (per cycle, combinational):
  - Candidate order pass 1: aged requesters (wait==MAX_WAIT), scanning indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Candidate order pass 2: non-aged valid requesters, same scan.
  - The first WB_PORTS candidates are granted. Port 0 takes the 1st candidate, port 1 the 2nd, and so on.
  - Unused ports are invalid.
- Latency:
  - A grant in cycle N produces wb_valid[p]=1 with that requester's payload in cycle N+1.
  - wb ports always accept; there is no backpressure from downstream.
  - Invalid ports register payload 0.
- rr_ptr update:
  - On at least one grant: rr_ptr <= (index of the last granted requester in scan order + 1) mod NUM_REQ.
  - No grant: rr_ptr holds.
  - Wrap-around: index NUM_REQ-1 followed by 0.
- Wait counters (8 bit, one per requester):
  - req_valid && !req_ready: increment, saturating at MAX_WAIT.
  - Granted or !req_valid: clear to 0.
- Flush:
  - req_ready=0 for all requesters in the flush cycle.
  - wb_valid <= 0 at the next edge; payload is don't-care.
  - Wait counters clear; rr_ptr holds.
  - Requesters are responsible for deasserting req_valid after flush.
- Simultaneous events:
  - Flush overrides grants.
  - More aged requesters than ports: the aged requesters are served in rotated-index order; the rest keep saturated counters and win the following cycles.
- Duplicate phys_rd among the granted requesters is not checked; uniqueness is guaranteed by rename.
- Reset asserted mid-operation: all state clears immediately and pending results are lost.

Test Plan:
- Reset, then req_valid=4'b0001, phys_rd0=5, data0=0xDEAD, rob0=3.
  - Expect req_ready=0001.
  - Next cycle: wb_valid=01, wb_phys_rd[0]=5, wb_data[0]=0xDEAD, wb_rob_addr[0]=3.
  - rr_ptr=1.
- req_valid=1111 held for 4 cycles with rr_ptr=0.
  - Grants: 0011, 1100, 0011, 1100.
  - rr_ptr sequence 2, 0, 2, 0; wb_valid=11 every cycle after the first.
- Wrap-around: rr_ptr=3, req_valid=1001.
  - Expect port0=req3, port1=req0; rr_ptr becomes 1.
- Starvation, MAX_WAIT=2:
  - req0 and req1 always valid; req2 valid from cycle 0. Priority is forced so req2 loses 2 cycles.
  - When wait2==2, req2 is granted on port0 ahead of its rotated position; wait2 returns to 0.
- Flush: req_valid=1111 with flush=1.
  - Expect req_ready=0000 and wb_valid=00 next cycle.
  - Counters 0; rr_ptr unchanged.
- Async reset pulsed mid-cycle while wb_valid=11.
  - wb_valid drops to 00 immediately without a clock edge; rr_ptr=0.
